// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: registers decoded operands, maps funct3/funct7/class to the ALU opcode,
// forwards MEM/WB results and inserts a bubble on load-use. Optional macro: OPSTAGE_PERF_EN (stall counter).
module alu_operand_stage #(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_flush,
   input  logic               i_id_valid,
   output logic               o_id_ready,
   input  logic [XLEN-1:0]    i_id_pc,
   input  logic [RADDR_W-1:0] i_id_rs1,
   input  logic [RADDR_W-1:0] i_id_rs2,
   input  logic [XLEN-1:0]    i_id_rs1_data,
   input  logic [XLEN-1:0]    i_id_rs2_data,
   input  logic [RADDR_W-1:0] i_id_rd,
   input  logic [XLEN-1:0]    i_id_imm,
   input  logic [2:0]         i_id_funct3,
   input  logic               i_id_f7b5,
   input  logic [2:0]         i_id_class,
   input  logic               i_id_is_load,
   input  logic               i_ex_ready,
   output logic               o_ex_valid,
   output logic [RADDR_W-1:0] o_ex_rd,
   output logic [XLEN-1:0]    o_ex_pc,
   output logic [3:0]         o_opcode,
   output logic [XLEN-1:0]    o_alu_a,
   output logic [XLEN-1:0]    o_alu_b,
   output logic [XLEN-1:0]    o_ex_store_data,
   input  logic               i_mem_we,
   input  logic [RADDR_W-1:0] i_mem_rd,
   input  logic [XLEN-1:0]    i_mem_data,
   input  logic               i_wb_we,
   input  logic [RADDR_W-1:0] i_wb_rd,
   input  logic [XLEN-1:0]    i_wb_data
`ifdef OPSTAGE_PERF_EN
   ,
   output logic [31:0]        o_stall_cnt
`endif
);

   localparam logic [3:0] OP_NONE = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_AND  = 4'd3;
   localparam logic [3:0] OP_OR   = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_SLL  = 4'd6;
   localparam logic [3:0] OP_SRA  = 4'd7;
   localparam logic [3:0] OP_SRL  = 4'd8;
   localparam logic [3:0] OP_SLT  = 4'd9;
   localparam logic [3:0] OP_SLTU = 4'd10;

   localparam logic [RADDR_W-1:0] X0     = {RADDR_W{1'b0}};
   localparam logic [XLEN-1:0]    ZERO_W = {XLEN{1'b0}};
   localparam logic [XLEN-1:0]    FOUR_W = {{(XLEN-3){1'b0}}, 3'b100};

   // Shared ALU-class decode; the I-type variant ignores funct7[5] for ADD.
   function automatic logic [3:0] alu_decode(input logic [2:0] cls, input logic [2:0] f3,
                                             input logic f7b5);
      logic [3:0] op;
      op = OP_NONE;
      case (cls)
         3'd0, 3'd1: begin
            case (f3)
               3'b000:  op = (f7b5 && (cls == 3'd0)) ? OP_SUB : OP_ADD;
               3'b001:  op = OP_SLL;
               3'b010:  op = OP_SLT;
               3'b011:  op = OP_SLTU;
               3'b100:  op = OP_XOR;
               3'b101:  op = f7b5 ? OP_SRA : OP_SRL;
               3'b110:  op = OP_OR;
               3'b111:  op = OP_AND;
               default: op = OP_NONE;
            endcase
         end
         3'd2, 3'd3, 3'd4, 3'd6: op = OP_ADD;
         3'd5: begin
            case (f3)
               3'b000, 3'b001: op = OP_SUB;
               3'b100, 3'b101: op = OP_SLT;
               3'b110, 3'b111: op = OP_SLTU;
               default:        op = OP_NONE;
            endcase
         end
         default: op = OP_NONE;
      endcase
      return op;
   endfunction

   logic               r_valid;
   logic [XLEN-1:0]    r_pc;
   logic [RADDR_W-1:0] r_rd;
   logic [RADDR_W-1:0] r_rs1;
   logic [RADDR_W-1:0] r_rs2;
   logic [XLEN-1:0]    r_rs1_data;
   logic [XLEN-1:0]    r_rs2_data;
   logic [XLEN-1:0]    r_imm;
   logic [2:0]         r_class;
   logic [3:0]         r_opcode;
   logic               r_is_load;

   logic               w_adv;
   logic               w_haz;
   logic               w_rs2_used;
   logic               w_id_ready;
   logic [XLEN-1:0]    w_fwd_rs1;
   logic [XLEN-1:0]    w_fwd_rs2;
   logic [XLEN-1:0]    w_alu_a;
   logic [XLEN-1:0]    w_alu_b;

   // Handshake and load-use hazard detection against the instruction in EX.
   always_comb begin
      w_adv      = !r_valid || i_ex_ready;
      w_rs2_used = (i_id_class == 3'd0) || (i_id_class == 3'd2) || (i_id_class == 3'd5);
      w_haz      = r_valid && r_is_load && (r_rd != X0) &&
                   ((r_rd == i_id_rs1) || ((r_rd == i_id_rs2) && w_rs2_used));
      w_id_ready = w_adv && !w_haz && !i_flush;
   end

   // Stage register: flush beats capture, capture beats bubble, otherwise hold.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_valid    <= 1'b0;
         r_pc       <= ZERO_W;
         r_rd       <= X0;
         r_rs1      <= X0;
         r_rs2      <= X0;
         r_rs1_data <= ZERO_W;
         r_rs2_data <= ZERO_W;
         r_imm      <= ZERO_W;
         r_class    <= 3'd0;
         r_opcode   <= OP_NONE;
         r_is_load  <= 1'b0;
      end else if (i_flush) begin
         r_valid <= 1'b0;
      end else if (i_id_valid && w_id_ready) begin
         r_valid    <= 1'b1;
         r_pc       <= i_id_pc;
         r_rd       <= i_id_rd;
         r_rs1      <= i_id_rs1;
         r_rs2      <= i_id_rs2;
         r_rs1_data <= i_id_rs1_data;
         r_rs2_data <= i_id_rs2_data;
         r_imm      <= i_id_imm;
         r_class    <= i_id_class;
         r_opcode   <= alu_decode(i_id_class, i_id_funct3, i_id_f7b5);
         r_is_load  <= i_id_is_load;
      end else if (w_adv) begin
         r_valid <= 1'b0;
      end else begin
         r_valid <= r_valid;
      end
   end

   // Forwarding: MEM has the younger result so it wins over WB; x0 is never forwarded.
   always_comb begin
      if (i_mem_we && (i_mem_rd == r_rs1) && (r_rs1 != X0)) begin
         w_fwd_rs1 = i_mem_data;
      end else if (i_wb_we && (i_wb_rd == r_rs1) && (r_rs1 != X0)) begin
         w_fwd_rs1 = i_wb_data;
      end else begin
         w_fwd_rs1 = r_rs1_data;
      end
      if (i_mem_we && (i_mem_rd == r_rs2) && (r_rs2 != X0)) begin
         w_fwd_rs2 = i_mem_data;
      end else if (i_wb_we && (i_wb_rd == r_rs2) && (r_rs2 != X0)) begin
         w_fwd_rs2 = i_wb_data;
      end else begin
         w_fwd_rs2 = r_rs2_data;
      end
   end

   // Operand selection by instruction class.
   always_comb begin
      case (r_class)
         3'd3:       w_alu_a = ZERO_W;
         3'd4, 3'd6: w_alu_a = r_pc;
         default:    w_alu_a = w_fwd_rs1;
      endcase
      case (r_class)
         3'd1, 3'd2, 3'd3, 3'd4: w_alu_b = r_imm;
         3'd6:                   w_alu_b = FOUR_W;
         default:                w_alu_b = w_fwd_rs2;
      endcase
   end

   assign o_id_ready      = w_id_ready;
   assign o_ex_valid      = r_valid;
   assign o_ex_rd         = r_rd;
   assign o_ex_pc         = r_pc;
   assign o_opcode        = r_opcode;
   assign o_alu_a         = w_alu_a;
   assign o_alu_b         = w_alu_b;
   assign o_ex_store_data = w_fwd_rs2;

`ifdef OPSTAGE_PERF_EN
   logic [31:0] r_stall_cnt;

   // Count cycles where decode offers but is refused; wraps naturally.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_stall_cnt <= 32'd0;
      end else if (i_id_valid && !w_id_ready) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end else begin
         r_stall_cnt <= r_stall_cnt;
      end
   end

   assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed self-checking bench for alu_operand_stage (stall counter checked when OPSTAGE_PERF_EN is defined).
module tb_alu_operand_stage;

   logic        clk = 1'b0;
   logic        rst_n, flush, id_valid, id_ready;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [2:0]  id_funct3, id_class;
   logic        id_f7b5, id_is_load, ex_ready, ex_valid;
   logic [4:0]  ex_rd;
   logic [31:0] ex_pc, alu_a, alu_b, ex_store_data;
   logic [3:0]  opcode;
   logic        mem_we, wb_we;
   logic [4:0]  mem_rd, wb_rd;
   logic [31:0] mem_data, wb_data;
`ifdef OPSTAGE_PERF_EN
   logic [31:0] stall_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_operand_stage dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_id_valid(id_valid), .o_id_ready(id_ready),
      .i_id_pc(id_pc), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_rs1_data(id_rs1_data),
      .i_id_rs2_data(id_rs2_data), .i_id_rd(id_rd), .i_id_imm(id_imm), .i_id_funct3(id_funct3),
      .i_id_f7b5(id_f7b5), .i_id_class(id_class), .i_id_is_load(id_is_load), .i_ex_ready(ex_ready),
      .o_ex_valid(ex_valid), .o_ex_rd(ex_rd), .o_ex_pc(ex_pc), .o_opcode(opcode),
      .o_alu_a(alu_a), .o_alu_b(alu_b), .o_ex_store_data(ex_store_data),
      .i_mem_we(mem_we), .i_mem_rd(mem_rd), .i_mem_data(mem_data),
      .i_wb_we(wb_we), .i_wb_rd(wb_rd), .i_wb_data(wb_data)
`ifdef OPSTAGE_PERF_EN
      , .o_stall_cnt(stall_cnt)
`endif
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic [2:0] cls, input logic [2:0] f3, input logic f7,
                         input logic [4:0] rs1, input logic [31:0] d1,
                         input logic [4:0] rs2, input logic [31:0] d2,
                         input logic [4:0] rd, input logic [31:0] imm, input logic [31:0] pc,
                         input logic ld);
      id_valid = 1'b1; id_class = cls; id_funct3 = f3; id_f7b5 = f7;
      id_rs1 = rs1; id_rs1_data = d1; id_rs2 = rs2; id_rs2_data = d2;
      id_rd = rd; id_imm = imm; id_pc = pc; id_is_load = ld;
   endtask

   task automatic run_vec(input string tag, input logic [2:0] cls, input logic [2:0] f3,
                          input logic f7, input logic [3:0] eop, input logic [31:0] ea,
                          input logic [31:0] eb);
      set_id(cls, f3, f7, 5'd1, 32'h11, 5'd2, 32'h22, 5'd3, 32'h33, 32'h40, 1'b0);
      tick();
      check_eq({tag, " op"}, {28'd0, opcode}, {28'd0, eop});
      check_eq({tag, " A"}, alu_a, ea);
      check_eq({tag, " B"}, alu_b, eb);
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b1;
      id_valid = 1'b0; id_pc = 32'd0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_data = 32'd0;
      id_rs2_data = 32'd0; id_rd = 5'd0; id_imm = 32'd0; id_funct3 = 3'd0; id_f7b5 = 1'b0;
      id_class = 3'd0; id_is_load = 1'b0;
      mem_we = 1'b0; mem_rd = 5'd0; mem_data = 32'd0; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;

      // 1 reset
      tick(); tick();
      check_eq("rst ex_valid", {31'd0, ex_valid}, 32'd0);
      check_eq("rst opcode", {28'd0, opcode}, 32'd0);
      check_eq("rst alu_a", alu_a, 32'd0);
      check_eq("rst alu_b", alu_b, 32'd0);
      check_eq("rst id_ready", {31'd0, id_ready}, 32'd1);
`ifdef OPSTAGE_PERF_EN
      check_eq("rst stall_cnt", stall_cnt, 32'd0);
`endif
      rst_n = 1'b1;

      // 2 R-type SUB with one-cycle latency
      set_id(3'd0, 3'b000, 1'b1, 5'd1, 32'd5, 5'd2, 32'd3, 5'd3, 32'd0, 32'h100, 1'b0);
      #1;
      check_eq("sub ex_valid before", {31'd0, ex_valid}, 32'd0);
      tick();
      id_valid = 1'b0;
      check_eq("sub ex_valid", {31'd0, ex_valid}, 32'd1);
      check_eq("sub opcode", {28'd0, opcode}, 32'd2);
      check_eq("sub A", alu_a, 32'd5);
      check_eq("sub B", alu_b, 32'd3);
      check_eq("sub ex_rd", {27'd0, ex_rd}, 32'd3);
      check_eq("sub ex_pc", ex_pc, 32'h100);

      // decode and operand-select table
      run_vec("add",   3'd0, 3'b000, 1'b0, 4'd1,  32'h11, 32'h22);
      run_vec("sra",   3'd0, 3'b101, 1'b1, 4'd7,  32'h11, 32'h22);
      run_vec("srl",   3'd0, 3'b101, 1'b0, 4'd8,  32'h11, 32'h22);
      run_vec("sltu",  3'd0, 3'b011, 1'b0, 4'd10, 32'h11, 32'h22);
      run_vec("or",    3'd0, 3'b110, 1'b0, 4'd4,  32'h11, 32'h22);
      run_vec("xor",   3'd0, 3'b100, 1'b0, 4'd5,  32'h11, 32'h22);
      run_vec("addi",  3'd1, 3'b000, 1'b1, 4'd1,  32'h11, 32'h33);
      run_vec("slli",  3'd1, 3'b001, 1'b0, 4'd6,  32'h11, 32'h33);
      run_vec("andi",  3'd1, 3'b111, 1'b0, 4'd3,  32'h11, 32'h33);
      run_vec("ldst",  3'd2, 3'b010, 1'b0, 4'd1,  32'h11, 32'h33);
      run_vec("lui",   3'd3, 3'b000, 1'b0, 4'd1,  32'h00, 32'h33);
      run_vec("auipc", 3'd4, 3'b000, 1'b0, 4'd1,  32'h40, 32'h33);
      run_vec("jal",   3'd6, 3'b000, 1'b0, 4'd1,  32'h40, 32'h04);
      run_vec("bne",   3'd5, 3'b001, 1'b0, 4'd2,  32'h11, 32'h22);
      run_vec("blt",   3'd5, 3'b101, 1'b0, 4'd9,  32'h11, 32'h22);
      run_vec("bltu",  3'd5, 3'b110, 1'b0, 4'd10, 32'h11, 32'h22);
      run_vec("br010", 3'd5, 3'b010, 1'b0, 4'd0,  32'h11, 32'h22);
      set_id(3'd7, 3'b000, 1'b0, 5'd1, 32'h11, 5'd2, 32'h22, 5'd3, 32'h33, 32'h40, 1'b0);
      tick();
      check_eq("nop op", {28'd0, opcode}, 32'd0);

      // 3 forwarding priority and x0
      set_id(3'd0, 3'b000, 1'b0, 5'd5, 32'd1, 5'd5, 32'd2, 5'd6, 32'd0, 32'h80, 1'b0);
      tick();
      id_valid = 1'b0;
      mem_we = 1'b1; mem_rd = 5'd5; mem_data = 32'hAA;
      wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hBB;
      #1;
      check_eq("fwd mem A", alu_a, 32'hAA);
      check_eq("fwd mem store", ex_store_data, 32'hAA);
      tick();
      check_eq("fwd bubble A", alu_a, 32'hAA);
      mem_we = 1'b0; #1;
      check_eq("fwd wb A", alu_a, 32'hBB);
      wb_we = 1'b0; #1;
      check_eq("fwd none A", alu_a, 32'd1);
      mem_we = 1'b1; mem_rd = 5'd0; wb_we = 1'b1; wb_rd = 5'd0;
      set_id(3'd0, 3'b000, 1'b0, 5'd0, 32'd1, 5'd0, 32'd2, 5'd6, 32'd0, 32'h84, 1'b0);
      tick();
      id_valid = 1'b0;
      check_eq("fwd x0 A", alu_a, 32'd1);
      check_eq("fwd x0 B", alu_b, 32'd2);
      mem_we = 1'b0; wb_we = 1'b0;

      // hazard boundaries: I-type rs2 match and load to x0 do not stall
      set_id(3'd2, 3'b010, 1'b0, 5'd2, 32'h1000, 5'd0, 32'd0, 5'd8, 32'd4, 32'h90, 1'b1);
      tick();
      set_id(3'd1, 3'b000, 1'b0, 5'd3, 32'd0, 5'd8, 32'd0, 5'd9, 32'd1, 32'h94, 1'b0);
      #1;
      check_eq("haz itype rs2", {31'd0, id_ready}, 32'd1);
      id_class = 3'd0; #1;
      check_eq("haz rtype rs2", {31'd0, id_ready}, 32'd0);
      set_id(3'd2, 3'b010, 1'b0, 5'd2, 32'h1000, 5'd0, 32'd0, 5'd0, 32'd4, 32'h98, 1'b1);
      tick();
      set_id(3'd1, 3'b000, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd9, 32'd1, 32'h9C, 1'b0);
      #1;
      check_eq("haz load x0", {31'd0, id_ready}, 32'd1);
      id_valid = 1'b0;
      tick();

      // 4 load-use: one bubble then forwarded from MEM
      set_id(3'd2, 3'b010, 1'b0, 5'd2, 32'h1000, 5'd0, 32'd0, 5'd7, 32'd8, 32'hA0, 1'b1);
      tick();
      set_id(3'd1, 3'b000, 1'b0, 5'd7, 32'd0, 5'd0, 32'd0, 5'd10, 32'd3, 32'hA4, 1'b0);
      #1;
      check_eq("lu ready", {31'd0, id_ready}, 32'd0);
      tick();
      check_eq("lu bubble", {31'd0, ex_valid}, 32'd0);
      mem_we = 1'b1; mem_rd = 5'd7; mem_data = 32'h55;
      #1;
      check_eq("lu ready2", {31'd0, id_ready}, 32'd1);
      tick();
      id_valid = 1'b0;
      check_eq("lu ex_valid", {31'd0, ex_valid}, 32'd1);
      check_eq("lu ex_pc", ex_pc, 32'hA4);
      check_eq("lu A", alu_a, 32'h55);
      check_eq("lu B", alu_b, 32'd3);
      mem_we = 1'b0;

      // 5 back-pressure hold, then flush (fresh reset so the stall counter starts at 0)
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      set_id(3'd0, 3'b000, 1'b0, 5'd1, 32'd10, 5'd2, 32'd20, 5'd9, 32'd0, 32'h200, 1'b0);
      tick();
      set_id(3'd0, 3'b000, 1'b1, 5'd1, 32'd7, 5'd2, 32'd8, 5'd4, 32'd0, 32'h300, 1'b0);
      ex_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check_eq("hold ready", {31'd0, id_ready}, 32'd0);
         tick();
         check_eq("hold ex_pc", ex_pc, 32'h200);
         check_eq("hold ex_rd", {27'd0, ex_rd}, 32'd9);
         check_eq("hold opcode", {28'd0, opcode}, 32'd1);
         check_eq("hold ex_valid", {31'd0, ex_valid}, 32'd1);
      end
      flush = 1'b1; #1;
      check_eq("flush ready", {31'd0, id_ready}, 32'd0);
      tick();
      check_eq("flush ex_valid", {31'd0, ex_valid}, 32'd0);
`ifdef OPSTAGE_PERF_EN
      check_eq("stall_cnt", stall_cnt, 32'd4);
`endif
      flush = 1'b0; ex_ready = 1'b1; #1;
      check_eq("post flush ready", {31'd0, id_ready}, 32'd1);
      tick();
      id_valid = 1'b0;
      check_eq("post flush ex_valid", {31'd0, ex_valid}, 32'd1);
      check_eq("post flush ex_pc", ex_pc, 32'h300);
      check_eq("post flush opcode", {28'd0, opcode}, 32'd2);
      tick();
      check_eq("drain ex_valid", {31'd0, ex_valid}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
